// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
// Bundles the operand/result handshake of the bit-serial subtractor.
//   start  : request, honoured only while ready=1
//   A, B   : minuend / subtrahend, sampled on the accepted start cycle
//   ready  : block can accept start (IDLE or DONE)
//   busy   : serial subtraction in progress
//   done   : one-cycle result-valid pulse
//   D, Bo  : registered difference and final borrow, held until next completion
//   ovf    : signed overflow, present only when SERIAL_SUBTRACTOR_OVF_EN is defined
// Modports: master (requester side), slave (the subtractor).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;

  modport master (output start, A, B,
                  input  ready, busy, done, D, Bo, ovf);
  modport slave  (input  start, A, B,
                  output ready, busy, done, D, Bo, ovf);
`else
  modport master (output start, A, B,
                  input  ready, busy, done, D, Bo);
  modport slave  (input  start, A, B,
                  output ready, busy, done, D, Bo);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial two's-complement subtractor, D = A - B (mod 2^WIDTH), LSB first,
// one bit per clock through a single full-subtractor cell and a borrow flop.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (start/A/B in; ready/busy/done/D/Bo out)
// Parameter WIDTH : operand/result width, 2..32.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds the registered signed-overflow
// output bus.ovf, updated together with D.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// SHIFT | one result bit per cycle; busy=1, start ignored
// DONE  | done=1 for this cycle; start here restarts immediately
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             bit_a;
  logic             bit_b;
  logic             d_bit;
  logic             bout;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs.
  assign bit_a    = op_a[0];
  assign bit_b    = op_b[0];
  assign d_bit    = bit_a ^ bit_b ^ borrow;
  assign bout     = (~bit_a & bit_b) | (~bit_a & borrow) | (bit_b & borrow);
  // New bit enters at the MSB so the LSB-first stream ends up in place.
  assign res_next = (res >> 1) | {d_bit, {(WIDTH-1){1'b0}}};
  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      borrow <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_a   <= bus.A;
            op_b   <= bus.B;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= S_SHIFT;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          res    <= res_next;
          borrow <= bout;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            d_q   <= res_next;
            bo_q  <= bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // Borrow into the sign stage differs from borrow out of it.
            ovf_q <= borrow ^ bout;
`endif
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = (state != S_SHIFT);
  assign bus.busy  = (state == S_SHIFT);
  assign bus.done  = (state == S_DONE);
  assign bus.D     = d_q;
  assign bus.Bo    = bo_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_ovf();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int ua, ub, sa, sb, diff;
    ua   = int'(a);
    ub   = int'(b);
    sa   = a[W-1] ? ua - (1 << W) : ua;
    sb   = b[W-1] ? ub - (1 << W) : ub;
    diff = sa - sb;
    d    = W'(ua - ub);
    bo   = (ua < ub);
    ov   = (diff > (1 << (W-1)) - 1) || (diff < -(1 << (W-1)));
  endtask

  // Called at a negedge; presents start for one cycle, waits for done.
  // lat counts cycles from the start cycle to the done cycle (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic bo, output logic ov,
                        output int lat);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    lat       = -1;
    for (int c = 1; c <= 4*W; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
      end
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    d  = bus.D;
    bo = bus.Bo;
    ov = get_ovf();
  endtask

  vec_t         vecs[8];
  logic [W-1:0] got_d, exp_d;
  logic         got_bo, exp_bo, got_ov, exp_ov;
  int           lat;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    vecs[7] = '{8'h20, 8'h21, 8'hFF, 1'b1, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_D",     32'(bus.D),     32'd0);
    chk("rst_Bo",    32'(bus.Bo),    32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf",   32'(bus.ovf),   32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, got_d, got_bo, got_ov, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(W+1));
      chk($sformatf("vec%0d_D", i), 32'(got_d), 32'(vecs[i].d));
      chk($sformatf("vec%0d_Bo", i), 32'(got_bo), 32'(vecs[i].bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 32'(got_ov), 32'(vecs[i].ovf));
`endif
      @(negedge clk);
      chk($sformatf("vec%0d_done_1cyc", i), 32'(bus.done), 32'd0);
      chk($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'd1);
    end

    // start during SHIFT is ignored
    begin
      int n_done;
      int first;
      n_done    = 0;
      first     = -1;
      bus.start = 1'b1;
      bus.A     = 8'h10;
      bus.B     = 8'h01;
      for (int c = 1; c <= 3*W; c++) begin
        @(negedge clk);
        if (c == 1) bus.start = 1'b0;
        if (c == 3) begin
          chk("ign_busy", 32'(bus.busy), 32'd1);
          bus.start = 1'b1;
          bus.A     = 8'hAA;
          bus.B     = 8'h55;
        end
        if (c == 4) bus.start = 1'b0;
        if (bus.done) begin
          n_done++;
          if (first < 0) begin
            first = c;
            chk("ign_D", 32'(bus.D), 32'h0F);
            chk("ign_Bo", 32'(bus.Bo), 32'd0);
          end
        end
      end
      chk("ign_done_count", 32'(n_done), 32'd1);
      chk("ign_lat", 32'(first), 32'(W+1));
    end

    // Back-to-back: start held through DONE
    begin
      int first;
      int second;
      logic hold_ok;
      first     = -1;
      second    = -1;
      hold_ok   = 1'b1;
      bus.start = 1'b1;
      bus.A     = 8'h10;
      bus.B     = 8'h01;
      for (int c = 1; c <= 4*W; c++) begin
        @(negedge clk);
        if (c == 1) bus.start = 1'b0;
        if (c == W) begin
          bus.start = 1'b1;
          bus.A     = 8'h80;
          bus.B     = 8'h7F;
        end
        if (first >= 0 && c == first + 1) begin
          bus.start = 1'b0;
          bus.A     = W'($urandom);
          bus.B     = W'($urandom);
        end
        if (bus.done) begin
          if (first < 0) begin
            first = c;
            chk("b2b_first_D", 32'(bus.D), 32'h0F);
          end else if (second < 0) begin
            second = c;
          end
        end
        if (first >= 0 && second < 0 && c > first && bus.D !== 8'h0F) hold_ok = 1'b0;
        if (second >= 0) break;
      end
      chk("b2b_first_lat", 32'(first), 32'(W+1));
      chk("b2b_gap", 32'(second - first), 32'(W+1));
      chk("b2b_D", 32'(bus.D), 32'h01);
      chk("b2b_Bo", 32'(bus.Bo), 32'd0);
      chk("b2b_D_hold", 32'(hold_ok), 32'd1);
      @(negedge clk);
    end

    // Reset in the middle of SHIFT (cnt=4)
    begin
      int n_done;
      bus.start = 1'b1;
      bus.A     = 8'h33;
      bus.B     = 8'h11;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c == 1) bus.start = 1'b0;
      end
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(bus.ready), 32'd1);
      chk("mid_rst_busy",  32'(bus.busy),  32'd0);
      chk("mid_rst_done",  32'(bus.done),  32'd0);
      chk("mid_rst_D",     32'(bus.D),     32'd0);
      chk("mid_rst_Bo",    32'(bus.Bo),    32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      for (int c = 0; c < 2*W; c++) begin
        @(negedge clk);
        if (bus.done) n_done++;
      end
      chk("mid_no_done", 32'(n_done), 32'd0);
      run_op(8'h20, 8'h21, got_d, got_bo, got_ov, lat);
      chk("mid_after_lat", 32'(lat), 32'(W+1));
      chk("mid_after_D", 32'(got_d), 32'hFF);
      chk("mid_after_Bo", 32'(got_bo), 32'd1);
      @(negedge clk);
    end

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = {1'b1, {(W-1){1'b0}}};
      if ($urandom_range(0, 7) == 0) rb = {1'b0, {(W-1){1'b1}}};
      model(ra, rb, exp_d, exp_bo, exp_ov);
      run_op(ra, rb, got_d, got_bo, got_ov, lat);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(W+1));
      chk($sformatf("rnd%0d_D", i), 32'(got_d), 32'(exp_d));
      chk($sformatf("rnd%0d_Bo", i), 32'(got_bo), 32'(exp_bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), 32'(got_ov), 32'(exp_ov));
`endif
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
